ic_test_sequencer: RTL and testbench
====================================

# ic_test_sequencer

Drives stimulus vectors to the IC under test and checks its responses, using the `gate`/`tester` codes produced by the IC number decoder directly upstream. On `start` it latches those codes and walks every input combination for the selected gate width, applying the same vector to all gates in parallel. After a settle delay it samples the gate outputs and compares them against the expected logic function. It then reports a per-gate fail mask and an overall pass flag to the result/display stage.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling; legal range 1–255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; accepted only in IDLE.
- `gate`  in  3  function code: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR; other codes are illegal.
- `tester`  in  3  topology code: 000 hex 1-input NOT, 001 quad 2-input, 010 triple 3-input, 011 dual 4-input, 100 single 8-input; other codes are illegal.
- `resp`  in  6  gate outputs from the pin mux; gate g is on bit g.
- `stim`  out  8  input vector, shared by every gate; the low n bits are used.
- `busy`  out  1  high from the cycle after acceptance through DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `pass`  out  1  result of the last run; held until the next acceptance.
- `fail_mask`  out  6  per-gate mismatch flags; held until the next acceptance.
- `bad_code`  out  1  the last run was rejected because of an illegal code.
- `fail_vec`  out  8  index of the first failing vector (only under `ICT_STOP_ON_FAIL_EN`).

## Operation
- Topology table, giving n inputs / G gates / V vectors:
  - NOT: 1 / 6 / 2
  - 2-input: 2 / 4 / 4
  - 3-input: 3 / 3 / 8
  - 4-input: 4 / 2 / 16
  - 8-input: 8 / 1 / 256
- The vector counter is 9 bits wide. `stim` carries the counter's low 8 bits; bits n and above are zero.
- Expected output for each topology and function:
  - Tester 000: the expected output is ~v[0], and `gate` is ignored.
  - Other topologies: AND, OR, NAND and NOR are the reductions over v[n-1:0].
  - XOR: reduction parity.
- At each SAMPLE, every `resp[g]` with g < G that differs from the expected value sets `fail_mask[g]`, which is sticky for the run. Bits G and above of `resp` are ignored, and the corresponding `fail_mask` bits stay 0.
- State machine:
  - IDLE: on `start`, latch `gate`/`tester` and clear `fail_mask`, `pass` and `bad_code`.
    - Illegal code: go to DONE with `bad_code`=1.
    - Legal code: set vector=0, load the settle counter, go to SETTLE.
  - SETTLE: hold `stim`; after `SETTLE_CYCLES` cycles go to SAMPLE.
  - SAMPLE: compare for one cycle.
    - If this was the last vector (V-1): go to DONE.
    - Otherwise: vector+1, reload the counter, go to SETTLE.
  - DONE: `done`=1 and `pass` = (`fail_mask`==0 && !`bad_code`), then IDLE next cycle.
- `stim` is 0 in IDLE and DONE. `start` while busy is ignored. The latched codes do not follow input changes during a run.
- Reset values: state IDLE, `stim`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `bad_code`=0, `fail_vec`=0.
- Reset mid-run: the run is abandoned, with no `done` pulse.

## Timing
- Acceptance cycle = cycle 0. SETTLE for vector k spans cycles k(S+1)+1 … k(S+1)+S, and its SAMPLE is at cycle k(S+1)+S+1, where S = `SETTLE_CYCLES`.
- `done` asserts at cycle V(S+1)+1. For an illegal code, `done` asserts at cycle 1.
- `resp` is sampled registered-free in SAMPLE. `fail_mask` updates on the edge that ends SAMPLE, so it is visible when `done` asserts.
- `busy` falls in the cycle after `done`. The earliest next acceptance is the cycle after DONE.

## Configuration
- `ICT_STOP_ON_FAIL_EN` defined:
  - Any mismatch in SAMPLE goes straight to DONE, and `fail_vec` captures that vector index.
  - `fail_vec` clears on acceptance.
  - The run is shortened accordingly.
- `ICT_STOP_ON_FAIL_EN` undefined:
  - All V vectors always run.
  - `fail_vec` is tied to 0.

## Structure
- Shared package `ic_tester_pkg`:
  - gate and tester code localparams, shared with the decoder;
  - the state enum;
  - the n/G/V lookup.
- Sub-module `ic_expected_fn` (combinational): takes (gate, tester, vector) and outputs the expected output bit. The sequencer instantiates it once and compares it against all used `resp` bits.

## Test plan
- 7404 case (gate 000, tester 000), S=4: `resp`=~`stim[0]` on bits 0–5 gives `done` at cycle 11, `pass`=1, `fail_mask`=0; `stim` sequence 0,1.
- Quad NAND (010/001): bit 2 of `resp` stuck at 1 gives `fail_mask`=000100 and `pass`=0. With `ICT_STOP_ON_FAIL_EN`, `fail_vec`=3 and `done` at cycle 4·5+1=21.
- 8-input NAND (010/100), correct model: 256 vectors, `done` at cycle 1281, `pass`=1, `stim` wraps from 255 back to 0 in DONE.
- Illegal tester 101: `done` at cycle 1, `bad_code`=1, `pass`=0, no SETTLE entered.
- Triple NOR run with `rst` asserted at cycle 10: next cycle is IDLE with all outputs at reset values, and no `done` pulse.
- `start` pulsed during a quad XOR run, with `gate` changed to AND mid-run: the pulse is ignored, XOR is still checked, and `pass`=1 for a correct XOR model.

Source files
------------

// File: rtl/ic_tester_pkg.sv
// ic_tester_pkg: gate/tester code points shared with the IC number decoder,
// the sequencer state encoding and the per-topology lookups (inputs per gate,
// used-gate mask, last vector index).
package ic_tester_pkg;

    localparam logic [2:0] GATE_AND  = 3'b000;
    localparam logic [2:0] GATE_OR   = 3'b001;
    localparam logic [2:0] GATE_NAND = 3'b010;
    localparam logic [2:0] GATE_NOR  = 3'b011;
    localparam logic [2:0] GATE_XOR  = 3'b100;

    localparam logic [2:0] TESTER_NOT = 3'b000;
    localparam logic [2:0] TESTER_IN2 = 3'b001;
    localparam logic [2:0] TESTER_IN3 = 3'b010;
    localparam logic [2:0] TESTER_IN4 = 3'b011;
    localparam logic [2:0] TESTER_IN8 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Both codes must be inside their defined ranges for a run to start.
    function automatic logic code_legal(input logic [2:0] g, input logic [2:0] t);
        return (g <= GATE_XOR) && (t <= TESTER_IN8);
    endfunction

    // Number of inputs per gate (n).
    function automatic logic [3:0] topo_inputs(input logic [2:0] t);
        case (t)
            TESTER_NOT: return 4'd1;
            TESTER_IN2: return 4'd2;
            TESTER_IN3: return 4'd3;
            TESTER_IN4: return 4'd4;
            TESTER_IN8: return 4'd8;
            default:    return 4'd0;
        endcase
    endfunction

    // One bit per gate present in the package (G gates -> low G bits set).
    function automatic logic [5:0] topo_gate_mask(input logic [2:0] t);
        case (t)
            TESTER_NOT: return 6'b111111;
            TESTER_IN2: return 6'b001111;
            TESTER_IN3: return 6'b000111;
            TESTER_IN4: return 6'b000011;
            TESTER_IN8: return 6'b000001;
            default:    return 6'b000000;
        endcase
    endfunction

    // Index of the final vector (V-1).
    function automatic logic [8:0] topo_last_vec(input logic [2:0] t);
        case (t)
            TESTER_NOT: return 9'd1;
            TESTER_IN2: return 9'd3;
            TESTER_IN3: return 9'd7;
            TESTER_IN4: return 9'd15;
            TESTER_IN8: return 9'd255;
            default:    return 9'd0;
        endcase
    endfunction

    // Even/odd parity of an 8-bit word (1 = odd number of ones).
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ic_expected_fn.sv
// ic_expected_fn: combinational golden model of one gate of the selected
// package; returns the output a good gate produces for the given vector.
module ic_expected_fn
    import ic_tester_pkg::*;
(
    input  logic [2:0] gate,
    input  logic [2:0] tester,
    input  logic [7:0] vector,
    output logic       expected
);

    logic [3:0] n_s;
    logic [7:0] in_mask_s;
    logic [7:0] used_s;

    // Mask the vector to the gate width and evaluate the selected function.
    always_comb begin
        n_s       = topo_inputs(tester);
        in_mask_s = (n_s >= 4'd8) ? 8'hFF : ((8'd1 << n_s) - 8'd1);
        used_s    = vector & in_mask_s;
        expected  = 1'b0;
        if (tester == TESTER_NOT) begin
            expected = ~vector[0];
        end else begin
            case (gate)
                GATE_AND:  expected = &(used_s | ~in_mask_s);
                GATE_OR:   expected = |used_s;
                GATE_NAND: expected = ~(&(used_s | ~in_mask_s));
                GATE_NOR:  expected = ~(|used_s);
                GATE_XOR:  expected = parity8(used_s);
                default:   expected = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ic_test_sequencer.sv
// ic_test_sequencer: walks every input vector of the latched gate/tester
// selection, holds each for SETTLE_CYCLES, samples resp once and accumulates
// a sticky per-gate fail mask; reports pass/fail at DONE.
// Optional build macro: ICT_STOP_ON_FAIL_EN -- abort on the first mismatching
// vector and record its index in fail_vec (otherwise fail_vec is always 0).
module ic_test_sequencer
    import ic_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate,
    input  logic [2:0] tester,
    input  logic [5:0] resp,
    output logic [7:0] stim,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_mask,
    output logic       bad_code,
    output logic [7:0] fail_vec
);

`ifdef ICT_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t     state_r,     state_s;
    logic [2:0] gate_r,      gate_s;
    logic [2:0] tester_r,    tester_s;
    logic [8:0] vec_r,       vec_s;
    logic [7:0] cnt_r,       cnt_s;
    logic [7:0] stim_r,      stim_s;
    logic       busy_r,      busy_s;
    logic       done_r,      done_s;
    logic       pass_r,      pass_s,  pass_hold_s;
    logic [5:0] fail_mask_r, fail_mask_s;
    logic       bad_code_r,  bad_code_s;
    logic [7:0] fail_vec_r,  fail_vec_s;
    logic       exp_bit_s;
    logic [5:0] mism_s;

    ic_expected_fn u_expected_fn (
        .gate     (gate_r),
        .tester   (tester_r),
        .vector   (vec_r[7:0]),
        .expected (exp_bit_s)
    );

    // Compare the expected bit against every gate actually present.
    always_comb begin
        mism_s = ({6{exp_bit_s}} ^ resp) & topo_gate_mask(tester_r);
    end

    // Next-state and next-output logic; outputs are derived from the next state
    // so the registered copies line up with the state they belong to.
    always_comb begin
        state_s     = state_r;
        gate_s      = gate_r;
        tester_s    = tester_r;
        vec_s       = vec_r;
        cnt_s       = cnt_r;
        pass_hold_s = pass_r;
        fail_mask_s = fail_mask_r;
        bad_code_s  = bad_code_r;
        fail_vec_s  = fail_vec_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    gate_s      = gate;
                    tester_s    = tester;
                    fail_mask_s = 6'd0;
                    pass_hold_s = 1'b0;
                    bad_code_s  = 1'b0;
                    fail_vec_s  = 8'd0;
                    if (code_legal(gate, tester)) begin
                        vec_s   = 9'd0;
                        cnt_s   = SETTLE_LOAD;
                        state_s = ST_SETTLE;
                    end else begin
                        bad_code_s = 1'b1;
                        state_s    = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r <= 8'd1) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_SAMPLE: begin
                fail_mask_s = fail_mask_r | mism_s;
                if (STOP_ON_FAIL && (mism_s != 6'd0)) begin
                    fail_vec_s = vec_r[7:0];
                    state_s    = ST_DONE;
                end else if (vec_r == topo_last_vec(tester_r)) begin
                    state_s = ST_DONE;
                end else begin
                    vec_s   = vec_r + 9'd1;
                    cnt_s   = SETTLE_LOAD;
                    state_s = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        stim_s = ((state_s == ST_SETTLE) || (state_s == ST_SAMPLE)) ? vec_s[7:0] : 8'd0;
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
        pass_s = (state_s == ST_DONE) ? ((fail_mask_s == 6'd0) && !bad_code_s) : pass_hold_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gate_r      <= 3'd0;
            tester_r    <= 3'd0;
            vec_r       <= 9'd0;
            cnt_r       <= 8'd0;
            stim_r      <= 8'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_mask_r <= 6'd0;
            bad_code_r  <= 1'b0;
            fail_vec_r  <= 8'd0;
        end else begin
            state_r     <= state_s;
            gate_r      <= gate_s;
            tester_r    <= tester_s;
            vec_r       <= vec_s;
            cnt_r       <= cnt_s;
            stim_r      <= stim_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            fail_mask_r <= fail_mask_s;
            bad_code_r  <= bad_code_s;
            fail_vec_r  <= fail_vec_s;
        end
    end

    assign stim      = stim_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_mask = fail_mask_r;
    assign bad_code  = bad_code_r;
    assign fail_vec  = fail_vec_r;

endmodule

// File: tb/tb_ic_test_sequencer.sv
// tb_ic_test_sequencer: behavioural IC model drives resp from stim; a
// scoreboard queue holds the expected stim at each SAMPLE cycle, and each
// scenario task checks completion timing and the reported result.
module tb_ic_test_sequencer;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] gate;
    logic [2:0] tester;
    logic [5:0] resp;
    logic [7:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] fail_mask;
    logic       bad_code;
    logic [7:0] fail_vec;

    int n_vec  = 0;
    int n_fail = 0;
    int cycle_no = 0;
    int acc_cycle = 0;

    typedef struct {
        int         cyc;
        logic [7:0] stim;
    } sb_t;
    sb_t sb_q[$];

    logic [2:0] model_gate   = 3'd0;
    logic [2:0] model_tester = 3'd0;
    logic [5:0] model_used   = 6'b111111;
    logic [5:0] stuck1       = 6'd0;
    logic       model_bit;

    ic_test_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate      (gate),
        .tester    (tester),
        .resp      (resp),
        .stim      (stim),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .bad_code  (bad_code),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_no <= cycle_no + 1;

    // Good-gate behaviour by counting ones in the used inputs.
    function automatic logic model_fn(input logic [2:0] g, input logic [2:0] t, input logic [7:0] v);
        int n;
        int ones;
        case (t)
            3'd0: n = 1;
            3'd1: n = 2;
            3'd2: n = 3;
            3'd3: n = 4;
            default: n = 8;
        endcase
        if (t == 3'd0) return ~v[0];
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        case (g)
            3'd0: return ones == n;
            3'd1: return ones != 0;
            3'd2: return ones != n;
            3'd3: return ones == 0;
            3'd4: return ones[0];
            default: return 1'b0;
        endcase
    endfunction

    // IC under test: used gates follow the model (plus stuck-at-1 faults),
    // unused pins are driven wrong on purpose.
    always_comb begin
        model_bit = model_fn(model_gate, model_tester, stim);
        resp = ({6{model_bit}} ^ ~model_used) | stuck1;
    end

    // Scoreboard consumer: check stim at each expected SAMPLE cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0 && (cycle_no - acc_cycle) == sb_q[0].cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (stim !== e.stim) begin
                n_fail++;
                $display("FAIL sb_stim cycle %0d: got %0d want %0d", e.cyc, stim, e.stim);
            end
        end
    end

    task automatic launch(input logic [2:0] g, input logic [2:0] t, input int nvec);
        @(posedge clk); #1;
        gate = g;
        tester = t;
        start = 1'b1;
        acc_cycle = cycle_no;
        sb_q.delete();
        for (int k = 0; k < nvec; k++) sb_q.push_back('{k * (S + 1) + S + 1, 8'(k)});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int rel, output bit seen);
        seen = 1'b0;
        rel = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                rel = cycle_no - acc_cycle;
            end
        end
    endtask

    task automatic set_model(input logic [2:0] g, input logic [2:0] t, input logic [5:0] used);
        model_gate = g;
        model_tester = t;
        model_used = used;
        stuck1 = 6'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; gate = 3'd0; tester = 3'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (stim !== 8'd0) begin n_fail++; $display("FAIL reset_stim got %0d want 0", stim); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass); end
        n_vec++; if (fail_mask !== 6'd0) begin n_fail++; $display("FAIL reset_mask got %b want 0", fail_mask); end
        n_vec++; if (bad_code !== 1'b0) begin n_fail++; $display("FAIL reset_bad got %b want 0", bad_code); end
        n_vec++; if (fail_vec !== 8'd0) begin n_fail++; $display("FAIL reset_fvec got %0d want 0", fail_vec); end
    endtask

    task automatic test_not();
        int rel; bit seen;
        set_model(3'd0, 3'd0, 6'b111111);
        launch(3'd0, 3'd0, 2);
        wait_done(100, rel, seen);
        n_vec++; if (rel !== 11) begin n_fail++; $display("FAIL not_done_cycle got %0d want 11", rel); end
        n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL not_pass got %b want 1", pass); end
        n_vec++; if (fail_mask !== 6'd0) begin n_fail++; $display("FAIL not_mask got %b want 000000", fail_mask); end
        n_vec++; if (stim !== 8'd0) begin n_fail++; $display("FAIL not_stim_done got %0d want 0", stim); end
        n_vec++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL not_sb_left got %0d want 0", sb_q.size()); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL not_done_pulse got %b want 0", done); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL not_busy_after got %b want 0", busy); end
    endtask

    task automatic test_quad_nand_fail();
        int rel; bit seen;
        logic [7:0] want_fv;
`ifdef ICT_STOP_ON_FAIL_EN
        want_fv = 8'd3;
`else
        want_fv = 8'd0;
`endif
        set_model(3'd2, 3'd1, 6'b001111);
        stuck1 = 6'b000100;
        launch(3'd2, 3'd1, 4);
        wait_done(200, rel, seen);
        n_vec++; if (rel !== 21) begin n_fail++; $display("FAIL nand_done_cycle got %0d want 21", rel); end
        n_vec++; if (fail_mask !== 6'b000100) begin n_fail++; $display("FAIL nand_mask got %b want 000100", fail_mask); end
        n_vec++; if (pass !== 1'b0) begin n_fail++; $display("FAIL nand_pass got %b want 0", pass); end
        n_vec++; if (fail_vec !== want_fv) begin n_fail++; $display("FAIL nand_fail_vec got %0d want %0d", fail_vec, want_fv); end
        stuck1 = 6'd0;
    endtask

    task automatic test_nand8();
        int rel; bit seen;
        set_model(3'd2, 3'd4, 6'b000001);
        launch(3'd2, 3'd4, 256);
        wait_done(2000, rel, seen);
        n_vec++; if (rel !== 1281) begin n_fail++; $display("FAIL nand8_done_cycle got %0d want 1281", rel); end
        n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL nand8_pass got %b want 1", pass); end
        n_vec++; if (stim !== 8'd0) begin n_fail++; $display("FAIL nand8_stim_done got %0d want 0", stim); end
    endtask

    task automatic test_illegal();
        int rel; bit seen;
        launch(3'd0, 3'b101, 0);
        wait_done(20, rel, seen);
        n_vec++; if (rel !== 1) begin n_fail++; $display("FAIL illt_done_cycle got %0d want 1", rel); end
        n_vec++; if (bad_code !== 1'b1) begin n_fail++; $display("FAIL illt_bad got %b want 1", bad_code); end
        n_vec++; if (pass !== 1'b0) begin n_fail++; $display("FAIL illt_pass got %b want 0", pass); end
        n_vec++; if (stim !== 8'd0) begin n_fail++; $display("FAIL illt_stim got %0d want 0", stim); end
        launch(3'b110, 3'd1, 0);
        wait_done(20, rel, seen);
        n_vec++; if (rel !== 1) begin n_fail++; $display("FAIL illg_done_cycle got %0d want 1", rel); end
        n_vec++; if (bad_code !== 1'b1) begin n_fail++; $display("FAIL illg_bad got %b want 1", bad_code); end
    endtask

    task automatic test_back_to_back();
        int rel; bit seen;
        set_model(3'd4, 3'd1, 6'b001111);
        launch(3'd4, 3'd1, 4);
        repeat (6) @(posedge clk);
        #1 start = 1'b1; gate = 3'd0;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200, rel, seen);
        n_vec++; if (rel !== 21) begin n_fail++; $display("FAIL xor_done_cycle got %0d want 21", rel); end
        n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL xor_pass got %b want 1", pass); end
        n_vec++; if (bad_code !== 1'b0) begin n_fail++; $display("FAIL xor_bad got %b want 0", bad_code); end
        set_model(3'd1, 3'd1, 6'b001111);
        launch(3'd1, 3'd1, 4);
        wait_done(200, rel, seen);
        n_vec++; if (rel !== 21) begin n_fail++; $display("FAIL or_done_cycle got %0d want 21", rel); end
        n_vec++; if (pass !== 1'b1) begin n_fail++; $display("FAIL or_pass got %b want 1", pass); end
    endtask

    task automatic test_reset_mid_run();
        int rel; bit seen;
        set_model(3'd3, 3'd2, 6'b000111);
        launch(3'd3, 3'd2, 8);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_vec++; if (stim !== 8'd0) begin n_fail++; $display("FAIL rstmid_stim got %0d want 0", stim); end
        n_vec++; if (pass !== 1'b0) begin n_fail++; $display("FAIL rstmid_pass got %b want 0", pass); end
        n_vec++; if (fail_mask !== 6'd0) begin n_fail++; $display("FAIL rstmid_mask got %b want 0", fail_mask); end
        wait_done(80, rel, seen);
        n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done got %b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_not();
        test_quad_nand_fail();
        test_nand8();
        test_illegal();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
